// File: rtl/timer_digit_loader.sv
// Serial digit-load writer for the countdown timer. It captures an M:SS value
// and clocks the three BCD digits into the timer one at a time, minutes first.
module timer_digit_loader #(
    parameter int SETUP_CYCLES = 1,
    parameter int STROBE_WIDTH = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] minutos_in,
    input  logic [3:0] dezenas_in,
    input  logic [3:0] unidades_in,
    output logic [3:0] data_out,
    output logic       load_strobe,
    output logic       loadn_out,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, FINISH} state_t;

    localparam int CMAX = (SETUP_CYCLES > STROBE_WIDTH) ? SETUP_CYCLES : STROBE_WIDTH;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      dig_q [3];
    logic [3:0]      dig_d [3];
    logic [3:0]      data_q, data_d;
    logic            strobe_q, strobe_d;
    logic            loadn_q, loadn_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            bad_bcd;

    assign bad_bcd = (minutos_in > 4'd9) || (dezenas_in > 4'd5) || (unidades_in > 4'd9);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        loadn_d  = loadn_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    dig_d[0] = minutos_in;
                    dig_d[1] = dezenas_in;
                    dig_d[2] = unidades_in;
                    if (bad_bcd) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        loadn_d = 1'b0;
                        data_d  = minutos_in;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    state_d  = STROBE;
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == CW'(STROBE_WIDTH - 1)) begin
                    state_d  = HOLD;
                    strobe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (idx_q == 2'd2) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    loadn_d = 1'b1;
                    busy_d  = 1'b0;
                    data_d  = 4'd0;
                end else begin
                    state_d = SETUP;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                    data_d  = dig_q[idx_q + 2'd1];
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort cuts any active digit transfer, including a strobe mid-pulse.
        if (abort && (state_q == SETUP || state_q == STROBE || state_q == HOLD)) begin
            state_d  = IDLE;
            strobe_d = 1'b0;
            loadn_d  = 1'b1;
            busy_d   = 1'b0;
            data_d   = 4'd0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            dig_q    <= '{default: 4'd0};
            data_q   <= 4'd0;
            strobe_q <= 1'b0;
            loadn_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            loadn_q  <= loadn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign data_out    = data_q;
    assign load_strobe = strobe_q;
    assign loadn_out   = loadn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_timer_digit_loader.sv
// Bench for timer_digit_loader: two instances (default timing and 2/3 timing)
// share stimulus and are checked every cycle against a schedule-based model.
module tb_timer_digit_loader;

    logic       clk = 1'b0;
    logic       clear, start, abort;
    logic [3:0] mi, de, un;

    logic [1:0][3:0] d_out;
    logic [1:0]      strb, ldn, bsy, dn, er;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        timer_digit_loader #(
            .SETUP_CYCLES((gi == 0) ? 1 : 2),
            .STROBE_WIDTH((gi == 0) ? 1 : 3)
        ) dut (
            .clk(clk), .clear(clear), .start(start), .abort(abort),
            .minutos_in(mi), .dezenas_in(de), .unidades_in(un),
            .data_out(d_out[gi]), .load_strobe(strb[gi]), .loadn_out(ldn[gi]),
            .busy(bsy[gi]), .done(dn[gi]), .error(er[gi])
        );
    end

    // Model: an accepted load is a timeline of 3 digit slots of S+W+1 cycles,
    // followed by one done cycle; outputs are a pure function of the position.
    function automatic int sc(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int wc(input int i); return (i == 0) ? 1 : 3; endfunction

    bit         armed = 1'b0;
    bit         act [2];
    bit         fin [2];
    int         k   [2];
    logic [3:0] dg  [2][3];
    logic [3:0] e_data [2];
    logic       e_strb [2], e_ldn [2], e_bsy [2], e_done [2], e_err [2];

    task automatic model_idle(input int i);
        e_data[i] = 4'd0; e_strb[i] = 1'b0; e_ldn[i] = 1'b1; e_bsy[i] = 1'b0;
    endtask

    task automatic model_step(input int i);
        int p_len, d, p;
        p_len = sc(i) + wc(i) + 1;
        e_done[i] = 1'b0;
        e_err[i]  = 1'b0;
        if (clear) begin
            act[i] = 1'b0; fin[i] = 1'b0; model_idle(i);
        end else if (act[i]) begin
            if (abort) begin
                act[i] = 1'b0; model_idle(i);
            end else if (k[i] == 3 * p_len) begin
                act[i] = 1'b0; fin[i] = 1'b1; model_idle(i); e_done[i] = 1'b1;
            end else begin
                k[i]++;
            end
        end else if (fin[i]) begin
            fin[i] = 1'b0;
        end else if (start && !abort) begin
            if (mi > 9 || de > 5 || un > 9) begin
                e_err[i] = 1'b1;
            end else begin
                act[i] = 1'b1; k[i] = 1;
                dg[i][0] = mi; dg[i][1] = de; dg[i][2] = un;
            end
        end
        if (act[i]) begin
            d = (k[i] - 1) / p_len;
            p = (k[i] - 1) % p_len;
            e_data[i] = dg[i][d];
            e_strb[i] = (p >= sc(i)) && (p < sc(i) + wc(i));
            e_ldn[i]  = 1'b0;
            e_bsy[i]  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (clear) armed <= 1'b1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic chk(input string nm, input int i, input logic [3:0] actual, input logic [3:0] expv);
        checks++;
        if (actual !== expv) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, i, $time, actual, expv);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk("data_out", i, d_out[i], e_data[i]);
                chk("load_strobe", i, {3'b0, strb[i]}, {3'b0, e_strb[i]});
                chk("loadn_out", i, {3'b0, ldn[i]}, {3'b0, e_ldn[i]});
                chk("busy", i, {3'b0, bsy[i]}, {3'b0, e_bsy[i]});
                chk("done", i, {3'b0, dn[i]}, {3'b0, e_done[i]});
                chk("error", i, {3'b0, er[i]}, {3'b0, e_err[i]});
            end
        end
    end

    task automatic lit(input string nm, input int actual, input int expv);
        checks++;
        if (actual != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, actual, expv);
        end
    endtask

    task automatic cyc(); @(negedge clk); endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 2; i++) begin
            lit("rst_loadn", ldn[i], 1);
            lit("rst_busy", bsy[i], 0);
            lit("rst_strobe", strb[i], 0);
            lit("rst_data", d_out[i], 0);
            lit("rst_done", dn[i], 0);
            lit("rst_error", er[i], 0);
        end
    endtask

    // Runs one load and pins its timing and strobed data with literal values.
    task automatic run_load(input int m, input int d, input int u, input bit hold);
        int         donec [2];
        int         hi    [2];
        logic [3:0] q0 [$];
        logic [3:0] q1 [$];
        logic       prev [2];
        donec = '{-1, -1}; hi = '{0, 0}; prev = '{1'b0, 1'b0};
        mi = 4'(m); de = 4'(d); un = 4'(u); start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                if (donec[i] < 0) begin
                    if (strb[i] && !prev[i]) begin
                        if (i == 0) q0.push_back(d_out[i]); else q1.push_back(d_out[i]);
                    end
                    if (strb[i]) hi[i]++;
                    if (dn[i]) donec[i] = c;
                end
                prev[i] = strb[i];
            end
            if (!hold || c >= 19) start = 1'b0;
            mi = 4'($urandom_range(0, 15)); de = 4'($urandom_range(0, 15)); un = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        lit("done_cycle_dut0", donec[0], 10);
        lit("done_cycle_dut1", donec[1], 19);
        lit("strobe_hi_cycles_dut0", hi[0], 3);
        lit("strobe_hi_cycles_dut1", hi[1], 9);
        lit("strobes_dut0", q0.size(), 3);
        lit("strobes_dut1", q1.size(), 3);
        if (q0.size() == 3 && q1.size() == 3) begin
            lit("digit0_dut0", q0[0], m); lit("digit1_dut0", q0[1], d); lit("digit2_dut0", q0[2], u);
            lit("digit0_dut1", q1[0], m); lit("digit1_dut1", q1[1], d); lit("digit2_dut1", q1[2], u);
        end
    endtask

    task automatic invalid_start(input int m, input int d, input int u);
        mi = 4'(m); de = 4'(d); un = 4'(u); start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lit("inv_error", er[i], 1);
            lit("inv_loadn", ldn[i], 1);
            lit("inv_busy", bsy[i], 0);
            lit("inv_strobe", strb[i], 0);
        end
        cyc();
        lit("inv_error_pulse_dut0", er[0], 0);
        lit("inv_error_pulse_dut1", er[1], 0);
    endtask

    initial begin
        int nstr [2];
        bit seen_done;
        clear = 1'b1; start = 1'b0; abort = 1'b0; mi = 4'd0; de = 4'd0; un = 4'd0;
        cyc(); cyc();
        check_reset_vals();
        clear = 1'b0;
        cyc();

        run_load(2, 0, 0, 1'b0);
        cyc(); cyc();
        run_load(9, 5, 9, 1'b0);
        run_load(0, 0, 0, 1'b0);
        invalid_start(1, 6, 0);
        invalid_start(1, 0, 10);

        // abort during the hold after the first strobe of the fast instance
        nstr = '{0, 0}; seen_done = 1'b0;
        mi = 4'd5; de = 4'd3; un = 4'd0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            for (int i = 0; i < 2; i++) if (strb[i]) nstr[i]++;
            if (dn != 2'b00) seen_done = 1'b1;
            if (c == 4) begin
                lit("abort_loadn", ldn[0], 1);
                lit("abort_busy", bsy[0], 0);
            end
            start = 1'b0;
            abort = (c == 3);
        end
        abort = 1'b0;
        lit("abort_strobes_dut0", nstr[0], 1);
        lit("abort_strobes_dut1", nstr[1], 1);
        lit("abort_no_done", seen_done, 0);
        run_load(5, 3, 0, 1'b0);

        run_load(4, 2, 7, 1'b1);
        cyc(); cyc();

        // clear in the middle of a sequence
        mi = 4'd7; de = 4'd4; un = 4'd5; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            start = 1'b0;
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_reset_vals();

        for (int n = 0; n < 3000; n++) begin
            cyc();
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 299) == 0);
            mi = 4'($urandom_range(0, 11));
            de = 4'($urandom_range(0, 7));
            un = 4'($urandom_range(0, 11));
        end
        start = 1'b0; abort = 1'b0; clear = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
